cpu_if_prefetch: RTL and testbench
==================================

# cpu_if_prefetch

Parametrised instruction-fetch stage with a small prefetch queue. It drives a combinational instruction ROM, buffers up to `DEPTH` fetched {pc, instruction} pairs, and presents the oldest one to ID with a valid/stall handshake. It accepts PC redirects from EX, stops fetching at a halt instruction, and keeps the global cycle counter. It sits between the global clock/clear and the ID stage, replacing the unbuffered fetch stage.

## Interface
Parameters:
- `ADDR_W`, 16: ROM address width; `rom_addr = fetch_pc[ADDR_W-1:0]` (byte address).
- `DEPTH`, 4: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, 32'h00000000: fetch PC after clear.
- `HALT_INS`, 32'h0000000C: instruction encoding that halts fetch (syscall).

Ports:
- `clk`  in  1  global clock.
- `clr`  in  1  synchronous, active-high reset.
- `stall`  in  1  ID cannot accept the head entry this cycle.
- `redirect`  in  1  EX redirect request (taken branch or jump).
- `redirect_pc`  in  32  new fetch PC, valid while `redirect` is high.
- `rom_addr`  out  ADDR_W  instruction ROM address.
- `rom_data`  in  32  ROM read data; combinational, same cycle as `rom_addr`.
- `valid`  out  1  head entry is present.
- `current_pc`  out  32  PC of the head entry.
- `ins`  out  32  instruction of the head entry.
- `cycle_count`  out  32  cycles since clear, starting at 1.
- `halt`  out  1  a halt instruction has been consumed by ID; sticky.
- `fifo_count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - Circular queue: `rd_ptr`/`wr_ptr` ($clog2(DEPTH) bits, wrapping) and `fifo_count`.
  - `fetch_stop` flag.
  - `halt` flag.
  - `cycle_count`.
- `pop = valid & ~stall & ~redirect & ~halt`.
- `push = ~redirect & ~fetch_stop & ~halt & (fifo_count < DEPTH | pop)`. A push into a full queue is allowed when a pop happens in the same cycle.
- Push writes {`fetch_pc`, `rom_data`} at `wr_ptr`, then `fetch_pc += 4` (mod 2^32).
  - If `rom_data == HALT_INS`, set `fetch_stop`. No further fetches happen until a redirect or clear.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- Redirect has priority over everything except `clr`:
  - The queue is flushed: pointers reset to 0 and `fifo_count` set to 0.
  - `fetch_pc <= redirect_pc`.
  - `fetch_stop` is cleared.
  - No push and no pop that cycle. A stall in the same cycle is irrelevant.
- Halt:
  - When a pop removes an entry whose `ins == HALT_INS`, `halt <= 1`.
  - Once `halt` is 1: no pushes or pops, `valid` is forced to 0, and `redirect` is ignored until `clr`.
- `cycle_count` increments by 1 each cycle while `halt == 0`. It saturates at 32'hFFFFFFFF and freezes when `halt` is set.
- `current_pc`/`ins` are read from the head storage entry. They hold the last head contents when `valid == 0`; ID must qualify them with `valid`.
- `rom_addr` is always `fetch_pc[ADDR_W-1:0]`, including during clear (after clear it equals `RESET_PC[ADDR_W-1:0]`).
- Reset (`clr` high at a clock edge) gives:
  - `fetch_pc = RESET_PC`
  - pointers = 0, `fifo_count` = 0
  - `valid` = 0
  - `fetch_stop` = 0
  - `halt` = 0
  - `cycle_count` = 1
  - Storage contents are don't-care.
- Clear mid-operation discards all queued entries and any pending redirect.

## Timing
- Fetch-to-head latency is 1 cycle. An entry pushed at edge N is valid (and poppable) in cycle N.
- First cycle after `clr` falls: push `RESET_PC`. `valid` = 1 from the next cycle onward.
- Redirect sampled at edge N:
  - queue empty after N;
  - `redirect_pc` is fetched in cycle N+1;
  - it is the head with `valid` = 1 after edge N+1.
- Sustained throughput with no stall: 1 instruction/cycle. The queue stays at occupancy 1.
- With `stall` held, the queue fills to `DEPTH` in `DEPTH` cycles, then fetch pauses. `fetch_pc` is held and `rom_addr` is stable.
- `halt` rises at the edge where the halt entry is popped. `cycle_count` shows its final value from that edge.

## Test plan
- Clear, ROM word at address a = 32'h1000+a, no stall:
  - `valid` from the 2nd cycle;
  - `current_pc` = 0, 4, 8… on consecutive cycles, with `ins` = 32'h1000, 32'h1004, …;
  - `fifo_count` = 1;
  - `cycle_count` = 1 in the first cycle after clear.
- Hold `stall` for 10 cycles with DEPTH=4:
  - `fifo_count` reaches 4 and stays;
  - `rom_addr` freezes at 16;
  - on release, entries 0, 4, 8, 12 pop in order, then 16.
- Full queue, then release `stall` for a single cycle:
  - push and pop occur together;
  - `fifo_count` stays 4;
  - the head moves 0→4.
- `redirect` = 1 with `redirect_pc` = 32'h40 and a simultaneous `stall`, when 3 entries are queued:
  - the next cycle has `fifo_count` = 0, `valid` = 0, `rom_addr` = 16'h40;
  - the cycle after has head PC 32'h40.
- Place HALT_INS at 32'h8:
  - the fetch of 32'h8 sets `fetch_stop`, and `rom_addr` stays at 16'hC;
  - after the pops of 0, 4, 8, `halt` = 1 and `valid` = 0;
  - `cycle_count` freezes;
  - a later `redirect` has no effect.
- Assert `clr` mid-stream with 2 entries queued:
  - next cycle all outputs are at reset values;
  - fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_if_prefetch.sv
// Instruction-fetch stage with a small circular prefetch queue.
// Drives a combinational ROM and buffers {pc, instruction} pairs.
// Presents the oldest pair to ID through a valid/stall handshake.
// Also handles EX redirects, halt-on-syscall and the global cycle counter.
module cpu_if_prefetch #(
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] HALT_INS = 32'h0000000C
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [31:0]              rom_data,
  output logic                     valid,
  output logic [31:0]              current_pc,
  output logic [31:0]              ins,
  output logic [31:0]              cycle_count,
  output logic                     halt,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             fetch_stop;
  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      ins_mem [DEPTH];
  logic             pop;
  logic             push;

  // Saturating increment so the counter parks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  assign rom_addr   = fetch_pc[ADDR_W-1:0];
  assign valid      = (fifo_count != '0) & ~halt;
  assign current_pc = pc_mem[rd_ptr];
  assign ins        = ins_mem[rd_ptr];

  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign pop  = valid & ~stall & ~redirect & ~halt;
  assign push = ~redirect & ~fetch_stop & ~halt & ((fifo_count < FULL) | pop);

  // Control state: fetch PC, queue pointers/occupancy, stop/halt flags, cycle counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      fetch_stop  <= 1'b0;
      halt        <= 1'b0;
      cycle_count <= 32'd1;
    end else begin
      if (!halt) begin
        cycle_count <= sat_inc(cycle_count);
      end
      if (!halt && redirect) begin
        fetch_pc   <= redirect_pc;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
        fetch_stop <= 1'b0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (ins == HALT_INS) begin
            halt <= 1'b1;
          end
        end
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + 32'd4;
          if (rom_data == HALT_INS) begin
            fetch_stop <= 1'b1;
          end
        end
        if (push && !pop) begin
          fifo_count <= fifo_count + 1'b1;
        end else if (pop && !push) begin
          fifo_count <= fifo_count - 1'b1;
        end
      end
    end
  end

  // Queue storage; contents are don't-care after clear, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= rom_data;
    end
  end

endmodule

// File: tb/tb_cpu_if_prefetch.sv
// Testbench for cpu_if_prefetch.
// A queue-based reference model is checked against the DUT on every cycle.
// Directed scenarios add hand-computed literal checks on top of the model.
module tb_cpu_if_prefetch;

  localparam int          ADDR_W   = 16;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] HALT_INS = 32'h0000000C;

  logic              clk = 1'b0;
  logic              clr;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              valid;
  logic [31:0]       current_pc;
  logic [31:0]       ins;
  logic [31:0]       cycle_count;
  logic              halt;
  logic [2:0]        fifo_count;

  // ROM: word at address a is 32'h1000+a, except an optional halt word.
  logic              halt_en;
  logic [ADDR_W-1:0] halt_addr;

  function automatic logic [31:0] rom_fn(input logic [ADDR_W-1:0] a);
    if (halt_en && a == halt_addr) return HALT_INS;
    return 32'h1000 + 32'(a);
  endfunction

  assign rom_data = rom_fn(rom_addr);

  cpu_if_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0), .HALT_INS(HALT_INS)) dut (
    .clk(clk), .clr(clr), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_data(rom_data), .valid(valid), .current_pc(current_pc),
    .ins(ins), .cycle_count(cycle_count), .halt(halt), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, ins} entries plus fetch/halt bookkeeping.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_stop;
  logic        m_halt;
  logic [31:0] m_cc;
  bit          m_init = 0;

  // Model update on each clock edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    logic        was_halt;
    logic        do_pop;
    logic        do_push;
    logic [31:0] word;
    if (clr) begin
      mq.delete();
      m_pc   = 32'h0;
      m_stop = 0;
      m_halt = 0;
      m_cc   = 32'd1;
      m_init = 1;
    end else if (m_init) begin
      was_halt = m_halt;
      if (!was_halt) begin
        if (redirect) begin
          mq.delete();
          m_pc   = redirect_pc;
          m_stop = 0;
        end else begin
          do_pop  = (mq.size() > 0) && !stall;
          do_push = !m_stop && ((mq.size() < DEPTH) || do_pop);
          word    = rom_fn(m_pc[ADDR_W-1:0]);
          if (do_pop) begin
            if (mq[0][31:0] == HALT_INS) m_halt = 1;
            void'(mq.pop_front());
          end
          if (do_push) begin
            mq.push_back({m_pc, word});
            if (word == HALT_INS) m_stop = 1;
            m_pc = m_pc + 32'd4;
          end
        end
        if (m_cc != 32'hFFFFFFFF) m_cc = m_cc + 32'd1;
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("m_valid", 32'(valid), 32'((mq.size() > 0) && !m_halt));
      chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("m_rom_addr", 32'(rom_addr), 32'(m_pc[ADDR_W-1:0]));
      chk("m_halt", 32'(halt), 32'(m_halt));
      chk("m_cycle_count", cycle_count, m_cc);
      if (valid && mq.size() > 0) begin
        chk("m_current_pc", current_pc, mq[0][63:32]);
        chk("m_ins", ins, mq[0][31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    halt_en = 1'b0; halt_addr = 16'h8;
    tick(); tick();

    // Reset state while clear is held.
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd1);
    chk("rst_halt", 32'(halt), 32'd0);

    // Streaming with no stall: one instruction per cycle, occupancy 1.
    clr = 1'b0;
    chk("first_cycle_cc", cycle_count, 32'd1);
    chk("first_cycle_valid", 32'(valid), 32'd0);
    tick();
    chk("stream0_pc", current_pc, 32'h0);
    chk("stream0_ins", ins, 32'h1000);
    chk("stream0_cnt", 32'(fifo_count), 32'd1);
    chk("stream0_cc", cycle_count, 32'd2);
    tick();
    chk("stream1_pc", current_pc, 32'h4);
    chk("stream1_ins", ins, 32'h1004);
    tick();
    chk("stream2_pc", current_pc, 32'h8);
    chk("stream2_cnt", 32'(fifo_count), 32'd1);

    // Stall held: queue fills to DEPTH and fetch freezes.
    do_clear();
    stall = 1'b1;
    repeat (10) tick();
    chk("stall_cnt", 32'(fifo_count), 32'd4);
    chk("stall_rom_addr", 32'(rom_addr), 32'h10);
    chk("stall_head", current_pc, 32'h0);
    // Single-cycle release: simultaneous push and pop on a full queue.
    stall = 1'b0;
    tick();
    chk("rel1_cnt", 32'(fifo_count), 32'd4);
    chk("rel1_head", current_pc, 32'h4);
    chk("rel1_rom_addr", 32'(rom_addr), 32'h14);
    stall = 1'b1;
    tick();
    chk("hold_head", current_pc, 32'h4);
    stall = 1'b0;
    tick(); chk("drain_8", current_pc, 32'h8);
    tick(); chk("drain_12", current_pc, 32'hC);
    tick(); chk("drain_16", current_pc, 32'h10);

    // Redirect with stall and 3 entries queued.
    do_clear();
    stall = 1'b1;
    repeat (3) tick();
    chk("pre_redir_cnt", 32'(fifo_count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("redir_cnt", 32'(fifo_count), 32'd0);
    chk("redir_valid", 32'(valid), 32'd0);
    chk("redir_rom_addr", 32'(rom_addr), 32'h40);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("redir_head_pc", current_pc, 32'h40);
    chk("redir_head_ins", ins, 32'h1040);
    chk("redir_head_valid", 32'(valid), 32'd1);

    // Halt instruction at address 8.
    halt_en = 1'b1; halt_addr = 16'h8;
    do_clear();
    tick(); tick(); tick();
    chk("stop_rom_addr", 32'(rom_addr), 32'hC);
    chk("stop_head", current_pc, 32'h8);
    tick();
    chk("halt_set", 32'(halt), 32'd1);
    chk("halt_valid", 32'(valid), 32'd0);
    chk("halt_cc", cycle_count, 32'd5);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    tick();
    chk("halt_redir_rom", 32'(rom_addr), 32'hC);
    chk("halt_cc_frozen", cycle_count, 32'd5);
    chk("halt_sticky", 32'(halt), 32'd1);
    halt_en = 1'b0;

    // Clear mid-stream with 2 entries queued.
    do_clear();
    stall = 1'b1;
    tick(); tick();
    chk("mid_pre_cnt", 32'(fifo_count), 32'd2);
    clr = 1'b1;
    tick();
    chk("mid_clr_cnt", 32'(fifo_count), 32'd0);
    chk("mid_clr_valid", 32'(valid), 32'd0);
    chk("mid_clr_cc", cycle_count, 32'd1);
    chk("mid_clr_rom", 32'(rom_addr), 32'd0);
    clr = 1'b0; stall = 1'b0;
    tick();
    chk("mid_restart_pc", current_pc, 32'h0);
    chk("mid_restart_ins", ins, 32'h1000);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
